bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
- Read-side sequencer for the dual-address coefficient BRAM: walks a contiguous address range and turns its 1-cycle registered-address read port into a valid/ready coefficient stream.
- Sits between a BRAM instance and the downstream multiplier datapath, absorbing BRAM read latency and downstream backpressure with a 2-entry output FIFO and credit-based read issue.

Parameters:
- D_SIZE, 52, coefficient word width; must match the BRAM data width.
- Q_DEPTH, 8, BRAM address width; Q_SIZE = 2^Q_DEPTH words.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin transfer; sampled only in IDLE.
- base_addr  in  Q_DEPTH  first word address; captured on accepted start.
- len  in  Q_DEPTH+1  word count, 0..Q_SIZE; captured on accepted start.
- busy  out  1  high from the cycle after the accepted start until done.
- done  out  1  one-cycle pulse after the last beat handshakes, or for len=0.
- rd_addr  out  Q_DEPTH  BRAM read address; registered output.
- rd_dout  in  D_SIZE  BRAM read data, valid the cycle after rd_addr is presented.
- m_data  out  D_SIZE  stream data (FIFO head).
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready; beat transfers when m_valid && m_ready.
- m_last  out  1  high with the final beat of the transfer.

Behaviour:
- Reset values: busy=0, done=0, m_valid=0, m_last=0, rd_addr=0, m_data=0. FIFO count, in-flight flag, and issue/beat counters are 0. State is IDLE.
- States:
  - IDLE: start=1 captures base_addr/len. If len=0, go to FIN. Otherwise go to RUN with issue_cnt=0 and beat_cnt=0.
  - RUN: issue reads until issue_cnt=len, then wait for beat_cnt=len and go to FIN.
  - FIN: done=1 for one cycle, busy=0, return to IDLE.
- start while not in IDLE is ignored.
- Issue rule, evaluated each RUN cycle: issue = (issue_cnt < len) && (fifo_count + inflight - pop) < 2, where pop = m_valid && m_ready.
  - On issue, rd_addr takes the current address this cycle, the address register increments at the edge, and inflight is set for the next cycle.
  - Address increments modulo Q_SIZE: after 2^Q_DEPTH-1 comes 0.
- Capture: in the cycle after an issue, rd_dout is written into the FIFO at the edge. Capture never overflows, guaranteed by the credit rule. Simultaneous capture and pop in one cycle are both honoured.
- m_last is tagged on the FIFO entry whose word index is len-1.
- Latency:
  - start sampled at edge 0; first rd_addr presented in cycle 1.
  - Data captured at edge 2; m_valid first high in cycle 3.
  - Sustained throughput is 1 beat/cycle while m_ready is held high.
- Backpressure: m_data, m_valid, and m_last stay stable while m_valid && !m_ready. Issue stalls once the credit reaches 2.
- done asserts in the cycle after the last-beat handshake. busy falls in the same cycle done pulses.
- rst mid-transfer:
  - Next cycle: IDLE, FIFO flushed, in-flight read discarded, m_valid=0.
  - No done pulse is produced.
- len=Q_SIZE reads every word exactly once, starting and ending around base_addr with wrap.

Decomposition:
- Shared package: state encoding (IDLE, RUN, FIN), default D_SIZE/Q_DEPTH constants, and a Q_SIZE helper.
- One natural sub-module: bram_skid_fifo2, a 2-entry FIFO with count output, carrying {last, data}.
- Address/credit logic and the FSM stay in the top module.

Test Plan:
- Preload BRAM with word[i]=i+100. Start base=10, len=4, m_ready=1.
  - Required: m_data 110,111,112,113 in consecutive cycles 3..6, m_last on 113, done in cycle 7.
- Backpressure: base=0, len=8, m_ready toggling 1,0,0,1,...
  - Required: all 8 words in order with none lost or duplicated; stable m_data while stalled; at most 2 reads outstanding+buffered.
- Wrap: base=254, len=4.
  - Required: rd_addr sequence 254,255,0,1; data matches word[254],word[255],word[0],word[1].
- len=0 start.
  - Required: no m_valid; done pulses 2 cycles after start; busy never high for more than the FIN cycle.
- rst asserted while 2 words are buffered and m_ready=0.
  - Required: next cycle m_valid=0, busy=0, no done. A fresh start base=5, len=1 then returns word[5] with m_last.
- start pulsed mid-transfer with different base/len.
  - Required: ignored; the original transfer completes unchanged.

Source files
------------

// File: rtl/bram_stream_reader_pkg.sv
// Shared state encoding, default sizes and helpers for the coefficient BRAM stream reader.
package bram_stream_reader_pkg;

    localparam int D_SIZE_DEF  = 52;
    localparam int Q_DEPTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    function automatic int q_size(input int q_depth);
        return 32'sd1 << q_depth;
    endfunction

endpackage

// File: rtl/bram_skid_fifo2.sv
// Two-entry output FIFO holding {last, data}; the head entry is a register that drives the stream directly.
module bram_skid_fifo2 #(
    parameter int W = 53
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         valid,
    output logic [1:0]   count
);

    logic [W-1:0] head_r;
    logic [W-1:0] tail_r;
    logic [1:0]   count_r;
    logic         valid_r;
    logic [W-1:0] head_next_s;
    logic [W-1:0] tail_next_s;
    logic [1:0]   count_next_s;
    logic         pop_s;

    // Next head/tail/count; the tail only holds data while the head is occupied.
    always_comb begin
        head_next_s  = head_r;
        tail_next_s  = tail_r;
        count_next_s = count_r;
        pop_s        = pop && (count_r != 2'd0);
        case (count_r)
            2'd0: begin
                if (push) begin
                    head_next_s  = push_data;
                    count_next_s = 2'd1;
                end else begin
                    count_next_s = 2'd0;
                end
            end
            2'd1: begin
                if (push && pop_s) begin
                    head_next_s = push_data;
                end else if (push) begin
                    tail_next_s  = push_data;
                    count_next_s = 2'd2;
                end else if (pop_s) begin
                    count_next_s = 2'd0;
                end else begin
                    count_next_s = 2'd1;
                end
            end
            2'd2: begin
                if (push && pop_s) begin
                    head_next_s = tail_r;
                    tail_next_s = push_data;
                end else if (pop_s) begin
                    head_next_s  = tail_r;
                    count_next_s = 2'd1;
                end else begin
                    count_next_s = 2'd2;
                end
            end
            default: begin
                count_next_s = 2'd0;
            end
        endcase
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {W{1'b0}};
            tail_r  <= {W{1'b0}};
            count_r <= 2'd0;
            valid_r <= 1'b0;
        end else begin
            head_r  <= head_next_s;
            tail_r  <= tail_next_s;
            count_r <= count_next_s;
            valid_r <= (count_next_s != 2'd0);
        end
    end

    assign head  = head_r;
    assign valid = valid_r;
    assign count = count_r;

endmodule

// File: rtl/bram_stream_reader.sv
// Walks a contiguous BRAM address range and presents the words as a valid/ready stream,
// issuing reads only when the 2-entry output FIFO has room for the returning data.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int D_SIZE  = D_SIZE_DEF,
    parameter int Q_DEPTH = Q_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [Q_DEPTH-1:0] base_addr,
    input  logic [Q_DEPTH:0]   len,
    output logic               busy,
    output logic               done,
    output logic [Q_DEPTH-1:0] rd_addr,
    input  logic [D_SIZE-1:0]  rd_dout,
    output logic [D_SIZE-1:0]  m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last
);

    localparam int                 Q_SIZE   = q_size(Q_DEPTH);
    localparam logic [Q_DEPTH:0]   LEN_MAX  = (Q_DEPTH+1)'(Q_SIZE);
    localparam logic [Q_DEPTH:0]   CNT_ZERO = (Q_DEPTH+1)'(0);
    localparam logic [Q_DEPTH:0]   CNT_ONE  = (Q_DEPTH+1)'(1);
    localparam logic [Q_DEPTH-1:0] ADDR_ONE = Q_DEPTH'(1);

    state_t             state_r;
    state_t             state_next_s;
    logic [Q_DEPTH-1:0] addr_r;
    logic [Q_DEPTH:0]   len_r;
    logic [Q_DEPTH:0]   issue_cnt_r;
    logic [Q_DEPTH:0]   beat_cnt_r;
    logic               inflight_r;
    logic               inflight_last_r;
    logic               busy_r;
    logic               done_r;

    logic [1:0]         fifo_count_s;
    logic [D_SIZE:0]    fifo_head_s;
    logic               fifo_valid_s;
    logic               pop_s;
    logic               issue_s;
    logic               accept_s;
    logic               last_pop_s;
    logic               fin_pulse_s;
    logic               busy_next_s;
    logic [2:0]         credit_s;

    assign pop_s = fifo_valid_s && m_ready;

    // Next state, read issue against the FIFO credit, and the busy/done pulse sources.
    always_comb begin
        state_next_s = state_r;
        issue_s      = 1'b0;
        accept_s     = 1'b0;
        credit_s     = {1'b0, fifo_count_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        last_pop_s   = pop_s && ((beat_cnt_r + CNT_ONE) == len_r);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s     = 1'b1;
                    state_next_s = (len == CNT_ZERO) ? ST_FIN : ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                issue_s = (issue_cnt_r < len_r) && (credit_s < 3'd2);
                if (last_pop_s) begin
                    state_next_s = ST_FIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FIN: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        // A zero-length transfer spends its busy cycle in FIN and pulses done afterwards.
        fin_pulse_s = ((state_r == ST_RUN) && last_pop_s) ||
                      ((state_r == ST_FIN) && (len_r == CNT_ZERO));
        busy_next_s = (state_next_s == ST_RUN) ||
                      ((state_r == ST_IDLE) && (state_next_s == ST_FIN));
    end

    // FSM state and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= busy_next_s;
            done_r  <= fin_pulse_s;
        end
    end

    // Address walk, transfer counters and the one-deep in-flight read tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r          <= {Q_DEPTH{1'b0}};
            len_r           <= CNT_ZERO;
            issue_cnt_r     <= CNT_ZERO;
            beat_cnt_r      <= CNT_ZERO;
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            if (accept_s) begin
                addr_r      <= base_addr;
                len_r       <= (len > LEN_MAX) ? LEN_MAX : len;
                issue_cnt_r <= CNT_ZERO;
                beat_cnt_r  <= CNT_ZERO;
            end else begin
                if (issue_s) begin
                    addr_r      <= addr_r + ADDR_ONE;
                    issue_cnt_r <= issue_cnt_r + CNT_ONE;
                end else begin
                    addr_r      <= addr_r;
                    issue_cnt_r <= issue_cnt_r;
                end
                if (pop_s) begin
                    beat_cnt_r <= beat_cnt_r + CNT_ONE;
                end else begin
                    beat_cnt_r <= beat_cnt_r;
                end
            end
            inflight_r      <= issue_s;
            inflight_last_r <= issue_s && ((issue_cnt_r + CNT_ONE) == len_r);
        end
    end

    bram_skid_fifo2 #(
        .W (D_SIZE + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_r),
        .push_data ({inflight_last_r, rd_dout}),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .valid     (fifo_valid_s),
        .count     (fifo_count_s)
    );

    assign rd_addr = addr_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign m_data  = fifo_head_s[D_SIZE-1:0];
    assign m_valid = fifo_valid_s;
    assign m_last  = fifo_valid_s && fifo_head_s[D_SIZE];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: a BRAM model preloaded with word[i]=i+100 and
// a reference built from the address/length arithmetic of each transfer.
module tb_bram_stream_reader;

    localparam int DW = 52;
    localparam int QS = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    base_addr;
    logic [8:0]    len;
    logic          busy;
    logic          done;
    logic [7:0]    rd_addr;
    logic [DW-1:0] rd_dout;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    logic [DW-1:0] mem [0:QS-1];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rd_dout <= mem[rd_addr];

    bram_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_dout   (rd_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] exp_word(input int addr);
        return DW'((addr % QS) + 100);
    endfunction

    // mode 0: m_ready always 1 with cycle-exact checks; 1: ready every third cycle; 2: random ready.
    task automatic run_transfer(input int base, input int n, input int mode, input int inject);
        int idx;
        int cyc;
        int budget;
        int issued;
        bit fin;
        bit rdy;
        logic pv;
        logic pr;
        logic pl;
        logic [DW-1:0] pd;
        idx = 0; fin = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        budget = 20 + 6 * n;
        start = 1'b1; base_addr = 8'(base); len = 9'(n); m_ready = 1'b0;
        step();
        cyc = 1;
        start = 1'b0;
        while (!fin && cyc < budget) begin
            if (idx == n) begin
                checks++; if (done !== 1'b1) begin failures++; $display("FAIL done_pulse base=%0d: got %0b want 1", base, done); end
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_fall base=%0d: got %0b want 0", base, busy); end
                checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL valid_after base=%0d: got %0b want 0", base, m_valid); end
                fin = 1;
            end else begin
                checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_early cyc=%0d: got %0b want 0", cyc, done); end
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_high cyc=%0d: got %0b want 1", cyc, busy); end
                if (mode == 0 && cyc <= n) begin
                    checks++;
                    if (rd_addr !== 8'((base + cyc - 1) % QS)) begin
                        failures++; $display("FAIL rd_addr cyc=%0d: got %0d want %0d", cyc, rd_addr, (base + cyc - 1) % QS);
                    end
                end
                if (mode == 0) begin
                    checks++;
                    if (m_valid !== ((cyc >= 3) && (cyc < 3 + n))) begin
                        failures++; $display("FAIL valid_window cyc=%0d: got %0b want %0b", cyc, m_valid, (cyc >= 3) && (cyc < 3 + n));
                    end
                end
                if (pv && !pr) begin
                    checks++;
                    if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
                        failures++; $display("FAIL stall_stable cyc=%0d: got v=%0b d=%0d l=%0b want v=1 d=%0d l=%0b", cyc, m_valid, m_data, m_last, pd, pl);
                    end
                end
                if (n < QS) begin
                    issued = (int'(rd_addr) - base) & 255;
                    checks++;
                    if (issued - idx > 2 || issued < idx) begin
                        failures++; $display("FAIL credit cyc=%0d: got outstanding=%0d want 0..2", cyc, issued - idx);
                    end
                end
                if (mode == 0) rdy = 1'b1;
                else if (mode == 1) rdy = (cyc % 3 == 0);
                else rdy = 1'($urandom_range(0, 1));
                m_ready = rdy;
                if (cyc == inject) begin
                    start = 1'b1; base_addr = 8'(base + 100); len = 9'd3;
                end else begin
                    start = 1'b0;
                end
                if (m_valid && rdy) begin
                    checks++;
                    if (m_data !== exp_word(base + idx)) begin
                        failures++; $display("FAIL beat_data idx=%0d: got %0d want %0d", idx, m_data, exp_word(base + idx));
                    end
                    checks++;
                    if (m_last !== (idx == n - 1)) begin
                        failures++; $display("FAIL beat_last idx=%0d: got %0b want %0b", idx, m_last, idx == n - 1);
                    end
                    idx++;
                end
                pv = m_valid; pr = rdy; pd = m_data; pl = m_last;
                step();
                cyc++;
            end
        end
        start = 1'b0;
        m_ready = 1'b0;
        if (!fin) begin
            checks++; failures++;
            $display("FAIL timeout base=%0d len=%0d: got %0d beats want %0d", base, n, idx, n);
        end else begin
            step();
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_single: got %0b want 0", done); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = 8'd0; len = 9'd0;
        step();
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", m_valid); end
        checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_last: got %0b want 0", m_last); end
        checks++; if (rd_addr !== 8'd0) begin failures++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
        checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_data: got %0d want 0", m_data); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_zero_len();
        int busy_cycles;
        busy_cycles = 0;
        start = 1'b1; base_addr = 8'd33; len = 9'd0; m_ready = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (busy === 1'b1) busy_cycles++;
            checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL zero_valid c=%0d: got %0b want 0", c, m_valid); end
            checks++; if (done !== (c == 2)) begin failures++; $display("FAIL zero_done c=%0d: got %0b want %0b", c, done, c == 2); end
            step();
        end
        checks++; if (busy_cycles > 1) begin failures++; $display("FAIL zero_busy: got %0d cycles want <=1", busy_cycles); end
        m_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        start = 1'b1; base_addr = 8'd0; len = 9'd8; m_ready = 1'b0;
        step();
        start = 1'b0;
        step(); step(); step();
        checks++; if (m_valid !== 1'b1 || m_data !== exp_word(0)) begin
            failures++; $display("FAIL rst_pre_buffer: got v=%0b d=%0d want v=1 d=%0d", m_valid, m_data, exp_word(0));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_valid c=%0d: got %0b want 0", c, m_valid); end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy c=%0d: got %0b want 0", c, busy); end
            checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done c=%0d: got %0b want 0", c, done); end
            step();
        end
        run_transfer(5, 1, 0, -1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 5; t++) begin
            run_transfer(int'($urandom_range(0, 255)), int'($urandom_range(1, 20)), int'($urandom_range(1, 2)), -1);
        end
    endtask

    initial begin
        for (int i = 0; i < QS; i++) mem[i] = DW'(i + 100);
        test_reset();
        run_transfer(10, 4, 0, -1);                               // basic latency/throughput
        run_transfer(0, 8, 1, -1);                                // backpressure
        run_transfer(254, 4, 0, -1);                              // address wrap
        test_zero_len();
        test_rst_mid();
        run_transfer(20, 6, 2, 4);                                // start while running is ignored
        test_random();
        run_transfer(int'($urandom_range(0, 255)), QS, 0, -1);    // full memory sweep
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
